// File: rtl/dmem_access_unit_pkg.sv
// cpu_defs: shared size encodings, exception codes and W-stage record for the load/store unit
package cpu_defs;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    typedef struct packed {
        logic        valid;
        logic        is_load;
        size_t       size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] raw;
        logic        adel;
        logic        ades;
    } wreg_t;
    function automatic logic misaligned(size_t s, logic [1:0] a);
        return s == SZ_BYTE ? 1'b0 : s == SZ_HALF ? a[0] : |a;
    endfunction
endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: M-stage request, data RAM port and W-stage result bundle
interface dmem_access_unit_if #(parameter int DMEM_AW = 8);
    logic               m_valid;
    logic               m_flush;
    logic               m_rd_en;
    logic               m_wr_en;
    logic [1:0]         m_size;
    logic               m_sext;
    logic [31:0]        m_addr;
    logic [31:0]        m_wdata;
    logic [3:0]         dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic [31:0]        dmem_rdata;
    logic               w_load_valid;
    logic [31:0]        w_rdata;
    logic               exc_adel;
    logic               exc_ades;
    logic               exc_pending;
    logic [31:0]        badvaddr;
    logic               exc_clr;
    modport master (
        output m_valid, m_flush, m_rd_en, m_wr_en, m_size, m_sext, m_addr, m_wdata, dmem_rdata, exc_clr,
        input  dmem_we, dmem_addr, dmem_wdata, w_load_valid, w_rdata, exc_adel, exc_ades, exc_pending, badvaddr
    );
    modport slave (
        input  m_valid, m_flush, m_rd_en, m_wr_en, m_size, m_sext, m_addr, m_wdata, dmem_rdata, exc_clr,
        output dmem_we, dmem_addr, dmem_wdata, w_load_valid, w_rdata, exc_adel, exc_ades, exc_pending, badvaddr
    );
endinterface

// File: rtl/dmem_access_unit_load_align.sv
// load_align: picks the addressed byte/half out of a raw RAM word and extends it to 32 bits
module load_align
    import cpu_defs::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        sext,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = offset == 2'd0 ? raw[7:0] : offset == 2'd1 ? raw[15:8] : offset == 2'd2 ? raw[23:16] : raw[31:24];
        h = offset[1] ? raw[31:16] : raw[15:0];
        data = size == SZ_BYTE ? {{24{sext & b[7]}}, b} :
               size == SZ_HALF ? {{16{sext & h[15]}}, h} : raw;
    end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: M-stage store lane steering, M->W load pipeline and sticky address-error record
module dmem_access_unit
    import cpu_defs::*;
#(
    parameter int DMEM_AW = 8
) (
    input logic               clk,
    input logic               rst,
    dmem_access_unit_if.slave bus
);
    size_t       sz;
    logic        m_act;
    logic        mis;
    logic        st_req;
    logic        is_ld;
    logic [3:0]  we_base;
    wreg_t       w;
    logic [31:0] aligned;
    logic        pending;
    logic [31:0] bad;

    assign sz      = size_t'(bus.m_size);
    assign m_act   = bus.m_valid & ~bus.m_flush;
    assign mis     = misaligned(sz, bus.m_addr[1:0]);
    assign st_req  = m_act & bus.m_wr_en;
    assign is_ld   = bus.m_rd_en & ~bus.m_wr_en;
    assign we_base = sz == SZ_BYTE ? 4'b0001 : sz == SZ_HALF ? 4'b0011 : 4'b1111;

    assign bus.dmem_we    = st_req & ~mis ? we_base << bus.m_addr[1:0] : 4'b0000;
    assign bus.dmem_addr  = bus.m_addr[DMEM_AW+1:2];
    assign bus.dmem_wdata = sz == SZ_BYTE ? {4{bus.m_wdata[7:0]}} :
                            sz == SZ_HALF ? {2{bus.m_wdata[15:0]}} : bus.m_wdata;

    always_ff @(posedge clk) begin
        if (!rst)
            w <= '0;
        else
            w <= m_act ? '{valid: 1'b1, is_load: is_ld, size: sz, sext: bus.m_sext, addr: bus.m_addr,
                           raw: bus.dmem_rdata, adel: is_ld & mis, ades: bus.m_wr_en & mis} : '0;
    end

    load_align u_align (
        .raw   (w.raw),
        .offset(w.addr[1:0]),
        .size  (w.size),
        .sext  (w.sext),
        .data  (aligned)
    );

    assign bus.w_load_valid = w.valid & w.is_load & ~w.adel;
    assign bus.w_rdata      = bus.w_load_valid ? aligned : 32'd0;
    assign bus.exc_adel     = w.adel;
    assign bus.exc_ades     = w.ades;

    // A new fault beats a coincident clear so it is never lost
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= 1'b0;
            bad     <= 32'd0;
        end else if ((w.adel | w.ades) && (!pending || bus.exc_clr)) begin
            pending <= 1'b1;
            bad     <= w.addr;
        end else if (bus.exc_clr)
            pending <= 1'b0;
    end

    assign bus.exc_pending = pending;
    assign bus.badvaddr    = bad;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: scoreboard bench with a negedge byte-writable RAM and a reference memory model
module tb_dmem_access_unit;
    localparam int AW = 8;
    logic clk = 1'b0;
    logic rst;
    dmem_access_unit_if #(.DMEM_AW(AW)) bus ();
    dmem_access_unit #(.DMEM_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [31:0] rd;
        logic        adel;
        logic        ades;
        logic [31:0] addr;
    } exp_t;

    logic [31:0] ram [2**AW] = '{default: 32'd0};
    logic [31:0] ref_mem [2**AW] = '{default: 32'd0};
    exp_t        sb [$];
    exp_t        cur = '{lv: 1'b0, rd: 32'd0, adel: 1'b0, ades: 1'b0, addr: 32'd0};
    int          checks = 0;
    int          errors = 0;
    logic        pend_m = 1'b0;
    logic [31:0] bad_m = 32'd0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.dmem_we[i]) ram[bus.dmem_addr][8*i +: 8] <= bus.dmem_wdata[8*i +: 8];
        bus.dmem_rdata <= ram[bus.dmem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rn, v, fl, rd, wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, wd, input logic clr);
        exp_t        e;
        logic        act, mis, st;
        logic [3:0]  we;
        logic [31:0] wdx, word;
        logic [7:0]  b;
        logic [15:0] h;
        logic [AW-1:0] idx;
        rst = rn; bus.m_valid = v; bus.m_flush = fl; bus.m_rd_en = rd; bus.m_wr_en = wr;
        bus.m_size = sz; bus.m_sext = sx; bus.m_addr = a; bus.m_wdata = wd; bus.exc_clr = clr;
        idx = a[AW+1:2];
        act = v & ~fl;
        mis = sz == 2'd0 ? 1'b0 : sz == 2'd1 ? a[0] : |a[1:0];
        st  = act & wr & ~mis;
        we  = !st ? 4'h0 : sz == 2'd0 ? 4'b0001 << a[1:0] : sz == 2'd1 ? 4'b0011 << a[1:0] : 4'hf;
        wdx = sz == 2'd0 ? {4{wd[7:0]}} : sz == 2'd1 ? {2{wd[15:0]}} : wd;
        #1;
        check("dmem_addr", 32'(bus.dmem_addr), 32'(idx));
        check("dmem_we", 32'(bus.dmem_we), 32'(we));
        if (we != 4'h0) check("dmem_wdata", bus.dmem_wdata, wdx);
        for (int i = 0; i < 4; i++)
            if (we[i]) ref_mem[idx][8*i +: 8] = wdx[8*i +: 8];
        word = ref_mem[idx];
        b = word[8*a[1:0] +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        e.adel = rn & act & rd & ~wr & mis;
        e.ades = rn & act & wr & mis;
        e.lv   = rn & act & rd & ~wr & ~mis;
        e.rd   = !e.lv ? 32'd0 : sz == 2'd0 ? {{24{sx & b[7]}}, b} : sz == 2'd1 ? {{16{sx & h[15]}}, h} : word;
        e.addr = a;
        sb.push_back(e);
        @(posedge clk);
        if (!rn) begin
            pend_m = 1'b0;
            bad_m  = 32'd0;
        end else if ((cur.adel | cur.ades) && (!pend_m || clr)) begin
            pend_m = 1'b1;
            bad_m  = cur.addr;
        end else if (clr)
            pend_m = 1'b0;
        #1;
        cur = sb.pop_front();
        check("w_load_valid", 32'(bus.w_load_valid), 32'(cur.lv));
        check("w_rdata", bus.w_rdata, cur.rd);
        check("exc_adel", 32'(bus.exc_adel), 32'(cur.adel));
        check("exc_ades", 32'(bus.exc_ades), 32'(cur.ades));
        check("exc_pending", 32'(bus.exc_pending), 32'(pend_m));
        check("badvaddr", bus.badvaddr, bad_m);
    endtask

    task automatic idle(input logic clr);
        step(1, 0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0, clr);
    endtask

    initial begin
        rst = 1'b0; bus.m_valid = 0; bus.m_flush = 0; bus.m_rd_en = 0; bus.m_wr_en = 0;
        bus.m_size = 0; bus.m_sext = 0; bus.m_addr = 0; bus.m_wdata = 0; bus.exc_clr = 0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0);
        step(1, 1, 0, 0, 1, 2'd2, 0, 32'h10, 32'hdeadbeef, 0);
        step(1, 1, 0, 1, 0, 2'd0, 1, 32'h13, 32'h0, 0);
        step(1, 1, 0, 1, 0, 2'd0, 0, 32'h13, 32'h0, 0);
        step(1, 1, 0, 0, 1, 2'd1, 0, 32'h22, 32'h8001, 0);
        step(1, 1, 0, 1, 0, 2'd1, 1, 32'h22, 32'h0, 0);
        step(1, 1, 0, 1, 0, 2'd1, 0, 32'h22, 32'h0, 0);
        step(1, 1, 0, 1, 0, 2'd0, 1, 32'h3, 32'h0, 0);
        step(1, 1, 0, 1, 0, 2'd2, 0, 32'h6, 32'h0, 0);
        step(1, 1, 0, 0, 1, 2'd2, 0, 32'h5, 32'h11111111, 0);
        idle(0);
        step(1, 1, 1, 0, 1, 2'd2, 0, 32'h10, 32'h12345678, 0);
        step(1, 1, 0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
        step(1, 1, 1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
        step(1, 1, 0, 0, 1, 2'd2, 0, 32'h40, 32'ha5a51234, 0);
        step(1, 1, 0, 1, 0, 2'd2, 0, 32'h40, 32'h0, 0);
        step(1, 1, 0, 0, 1, 2'd0, 0, 32'h41, 32'h77, 0);
        step(1, 1, 0, 1, 0, 2'd2, 0, 32'h40, 32'h0, 0);
        step(1, 1, 0, 1, 1, 2'd3, 0, 32'h44, 32'hcafef00d, 0);
        step(1, 1, 0, 1, 0, 2'd3, 0, 32'h44, 32'h0, 0);
        step(1, 1, 0, 1, 0, 2'd2, 0, 32'h7, 32'h0, 0);
        step(0, 0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0);
        step(1, 1, 0, 1, 0, 2'd2, 0, 32'h6, 32'h0, 0);
        step(1, 1, 0, 1, 0, 2'd1, 0, 32'h21, 32'h0, 0);
        idle(1);
        idle(0);
        idle(1);
        for (int i = 0; i < 60; i++) begin
            logic v, fl, rd, wr, sx, clr;
            logic [1:0] sz;
            v   = 1'($urandom_range(0, 3) != 0);
            fl  = 1'($urandom_range(0, 9) == 0);
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 2) == 0);
            sx  = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 9) == 0);
            sz  = 2'($urandom_range(0, 3));
            step(1, v, fl, rd, wr, sz, sx, 32'($urandom_range(0, 63)), $urandom, clr);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
